// File: rtl/apu_length_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : apu_length_counter_bank
// Brief    : Multi-channel APU length counters. Each counter decrements on the
//            half-frame tick (or every clock in free-running mode) and emits a
//            one-cycle expiry pulse when it steps from 1 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module apu_length_counter_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int FREE_RUN  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH-1:0]           halt,
    input  logic [NUM_CH-1:0]           load,
    input  logic [5*NUM_CH-1:0]         load_data,
    output logic [NUM_CH-1:0]           non_zero,
    output logic [NUM_CH-1:0]           expired,
    output logic [CNT_WIDTH*NUM_CH-1:0] count
);

    generate
        if (CNT_WIDTH < 8) begin : g_width_check
            $error("apu_length_counter_bank: CNT_WIDTH must be at least 8");
        end
    endgenerate

    function automatic logic [7:0] f_len_lut(input logic [4:0] i_idx);
        logic [7:0] w_val;
        case (i_idx)
            5'd0:  w_val = 8'd10;   5'd1:  w_val = 8'd254;
            5'd2:  w_val = 8'd20;   5'd3:  w_val = 8'd2;
            5'd4:  w_val = 8'd40;   5'd5:  w_val = 8'd4;
            5'd6:  w_val = 8'd80;   5'd7:  w_val = 8'd6;
            5'd8:  w_val = 8'd160;  5'd9:  w_val = 8'd8;
            5'd10: w_val = 8'd60;   5'd11: w_val = 8'd10;
            5'd12: w_val = 8'd14;   5'd13: w_val = 8'd12;
            5'd14: w_val = 8'd26;   5'd15: w_val = 8'd14;
            5'd16: w_val = 8'd12;   5'd17: w_val = 8'd16;
            5'd18: w_val = 8'd24;   5'd19: w_val = 8'd18;
            5'd20: w_val = 8'd48;   5'd21: w_val = 8'd20;
            5'd22: w_val = 8'd96;   5'd23: w_val = 8'd22;
            5'd24: w_val = 8'd192;  5'd25: w_val = 8'd24;
            5'd26: w_val = 8'd72;   5'd27: w_val = 8'd26;
            5'd28: w_val = 8'd16;   5'd29: w_val = 8'd28;
            5'd30: w_val = 8'd32;   default: w_val = 8'd30;
        endcase
        return w_val;
    endfunction

    logic w_dec;
    assign w_dec = (FREE_RUN != 0) ? 1'b1 : tick;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_exp;
            logic                 w_cnt_nz;
            logic                 w_load_ok;
            logic [CNT_WIDTH-1:0] w_load_val;

            assign w_cnt_nz   = |r_cnt;
            // A load colliding with a decrement event loses only when the
            // counter is still running; halt does not rescue it.
            assign w_load_ok  = load[g] && !(w_dec && w_cnt_nz);
            assign w_load_val = CNT_WIDTH'(f_len_lut(load_data[5*g +: 5]));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_exp <= 1'b0;
                end else if (!enable[g]) begin
                    r_cnt <= '0;
                    r_exp <= 1'b0;
                end else if (w_load_ok) begin
                    r_cnt <= w_load_val;
                    r_exp <= 1'b0;
                end else if (w_dec && !halt[g] && w_cnt_nz) begin
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                    r_exp <= (r_cnt == CNT_WIDTH'(1));
                end else begin
                    r_exp <= 1'b0;
                end
            end

            assign non_zero[g]                         = w_cnt_nz;
            assign expired[g]                          = r_exp;
            assign count[CNT_WIDTH*g +: CNT_WIDTH]     = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire
